// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the coprocessor-0 interrupt controller.
//   - CP0 register select codes (Status, Cause, EPC)
//   - Bit positions of the Status/Cause fields
//   - Width of the winning-channel index and the N_IRQ upper bound
package cp0_pkg;

  // Register select values (rd field of mfc0/mtc0)
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // Status fields
  localparam int ST_IE       = 0;
  localparam int ST_EXL      = 1;
  localparam int ST_MASK_LSB = 8;

  // Cause fields
  localparam int CA_PEND_LSB = 8;
  localparam int CA_IDX_LSB  = 2;

  // Index width covers up to N_IRQ_MAX channels
  localparam int N_IRQ_MAX = 8;
  localparam int IDX_W     = 3;

endpackage

// File: rtl/cp0_prio_enc.sv
// cp0_prio_enc: lowest-index-first priority encoder.
// Ports:
//   req_i   [N-1:0]      request vector
//   valid_o              any request present
//   idx_o   [IDX_W-1:0]  index of the lowest set request (0 when none)
//   grant_o [N-1:0]      one-hot of the winning request (0 when none)
module cp0_prio_enc
  import cp0_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [N-1:0]     grant_o
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    grant_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o      = IDX_W'(i);
        grant_o    = '0;
        grant_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_intc.sv
// cp0_intc: coprocessor-0 interrupt controller for the single-cycle MIPS core.
// Masked, prioritised hardware interrupts with Status/Cause/EPC registers,
// vectored entry and an rfe return path.
// Build option: define CP0_EDGE_EN for sticky edge-triggered PEND bits
// (write-1-to-clear via Cause); otherwise PEND follows hwint (level mode).
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   hwint      [N_IRQ-1:0]    device interrupt lines
//   retire                    instruction completes this cycle
//   pc_next    [31:0]         PC the core would load without an interrupt
//   rfe                       return-from-exception retiring
//   mtc0_en, cp0_sel, cp0_wdata  CP0 register write port
//   cp0_rdata  [31:0]         combinational read of cp0_sel
//   exc_take                  load exc_vector instead of pc_next this edge
//   exc_vector [31:0]         entry address of the current winner
//   epc        [31:0]         current EPC
//   irq_ack    [N_IRQ-1:0]    one-hot pulse the cycle after a take
module cp0_intc
  import cp0_pkg::*;
#(
  parameter int          N_IRQ     = 4,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
  parameter int          VEC_SHIFT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_IRQ-1:0] hwint,
  input  logic             retire,
  input  logic [31:0]      pc_next,
  input  logic             rfe,
  input  logic             mtc0_en,
  input  logic [4:0]       cp0_sel,
  input  logic [31:0]      cp0_wdata,
  output logic [31:0]      cp0_rdata,
  output logic             exc_take,
  output logic [31:0]      exc_vector,
  output logic [31:0]      epc,
  output logic [N_IRQ-1:0] irq_ack
);

  logic             ie_q, ie_d;
  logic             exl_q, exl_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      epc_q, epc_d;
  logic [N_IRQ-1:0] ack_q, ack_d;

  logic [N_IRQ-1:0] pend;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] grant;
  logic             win_valid;
  logic [IDX_W-1:0] win_idx;

  logic wr_status, wr_epc;
  assign wr_status = mtc0_en && (cp0_sel == CP0_STATUS);
  assign wr_epc    = mtc0_en && (cp0_sel == CP0_EPC);

  // Upper write-data bits have no destination in every configuration.
  logic unused_wdata;
  assign unused_wdata = ^cp0_wdata;

`ifdef CP0_EDGE_EN
  logic [N_IRQ-1:0] hwint_q;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] pend_clr;
  logic             wr_cause;

  assign wr_cause = mtc0_en && (cp0_sel == CP0_CAUSE);

  // Clear on take or W1C write; a new rising edge on the same cycle wins.
  always_comb begin
    pend_clr = exc_take ? grant : '0;
    if (wr_cause) begin
      pend_clr = pend_clr | cp0_wdata[CA_PEND_LSB +: N_IRQ];
    end
    pend_d = (pend_q & ~pend_clr) | (hwint & ~hwint_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hwint_q <= '0;
      pend_q  <= '0;
    end else begin
      hwint_q <= hwint;
      pend_q  <= pend_d;
    end
  end

  assign pend = pend_q;
`else
  assign pend = hwint;
`endif

  assign eligible = pend & mask_q;

  cp0_prio_enc #(.N(N_IRQ)) u_prio (
    .req_i   (eligible),
    .valid_o (win_valid),
    .idx_o   (win_idx),
    .grant_o (grant)
  );

  assign exc_take   = retire & ie_q & ~exl_q & win_valid & ~rfe;
  // win_idx is 0 with no eligible channel, so the vector falls back to VEC_BASE.
  assign exc_vector = VEC_BASE + ({{(32 - IDX_W){1'b0}}, win_idx} << VEC_SHIFT);
  assign epc        = epc_q;
  assign irq_ack    = ack_q;

  always_comb begin
    cp0_rdata = '0;
    case (cp0_sel)
      CP0_STATUS: begin
        cp0_rdata[ST_IE]                   = ie_q;
        cp0_rdata[ST_EXL]                  = exl_q;
        cp0_rdata[ST_MASK_LSB +: N_IRQ]    = mask_q;
      end
      CP0_CAUSE: begin
        cp0_rdata[CA_PEND_LSB +: N_IRQ]    = pend;
        cp0_rdata[CA_IDX_LSB +: IDX_W]     = idx_q;
      end
      CP0_EPC:  cp0_rdata = epc_q;
      default:  cp0_rdata = '0;
    endcase
  end

  // Ordering: mtc0 first, then rfe, then take, so take owns EPC/EXL/index
  // while mtc0 still lands IE and MASK on the same edge.
  always_comb begin
    ie_d   = ie_q;
    exl_d  = exl_q;
    mask_d = mask_q;
    idx_d  = idx_q;
    epc_d  = epc_q;
    ack_d  = '0;
    if (wr_status) begin
      ie_d   = cp0_wdata[ST_IE];
      exl_d  = cp0_wdata[ST_EXL];
      mask_d = cp0_wdata[ST_MASK_LSB +: N_IRQ];
    end
    if (wr_epc) begin
      epc_d = cp0_wdata;
    end
    if (rfe) begin
      exl_d = 1'b0;
    end
    if (exc_take) begin
      epc_d = pc_next;
      exl_d = 1'b1;
      idx_d = win_idx;
      ack_d = grant;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ie_q   <= 1'b0;
      exl_q  <= 1'b0;
      mask_q <= '0;
      idx_q  <= '0;
      epc_q  <= '0;
      ack_q  <= '0;
    end else begin
      ie_q   <= ie_d;
      exl_q  <= exl_d;
      mask_q <= mask_d;
      idx_q  <= idx_d;
      epc_q  <= epc_d;
      ack_q  <= ack_d;
    end
  end

endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: directed plus randomized check of cp0_intc against a
// behavioural model of the register/interrupt rules.
module tb_cp0_intc;

  localparam int          N  = 4;
  localparam logic [31:0] VB = 32'h0000_0100;
  localparam int          VS = 4;
  localparam logic [31:0] NMASK = 32'h0000_000F;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  hwint = '0;
  logic          retire = 1'b0;
  logic [31:0]   pc_next = '0;
  logic          rfe = 1'b0;
  logic          mtc0_en = 1'b0;
  logic [4:0]    cp0_sel = '0;
  logic [31:0]   cp0_wdata = '0;
  logic [31:0]   cp0_rdata;
  logic          exc_take;
  logic [31:0]   exc_vector;
  logic [31:0]   epc;
  logic [N-1:0]  irq_ack;

  cp0_intc #(.N_IRQ(N), .VEC_BASE(VB), .VEC_SHIFT(VS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hwint      (hwint),
    .retire     (retire),
    .pc_next    (pc_next),
    .rfe        (rfe),
    .mtc0_en    (mtc0_en),
    .cp0_sel    (cp0_sel),
    .cp0_wdata  (cp0_wdata),
    .cp0_rdata  (cp0_rdata),
    .exc_take   (exc_take),
    .exc_vector (exc_vector),
    .epc        (epc),
    .irq_ack    (irq_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  bit          m_ie, m_exl;
  logic [31:0] m_mask, m_idx, m_epc, m_pend, m_hwprev, m_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ie = 0; m_exl = 0; m_mask = 0; m_idx = 0; m_epc = 0;
    m_pend = 0; m_hwprev = 0; m_ack = 0;
  endtask

  // Expected combinational view for the current inputs and state.
  function automatic void model_comb(output bit take, output logic [31:0] win,
                                     output logic [31:0] vec, output logic [31:0] rd);
    logic [31:0] pend, elig;
`ifdef CP0_EDGE_EN
    pend = m_pend;
`else
    pend = 32'(hwint);
`endif
    elig = pend & m_mask;
    win  = 0;
    for (int i = N - 1; i >= 0; i--) if (elig[i]) win = i;
    take = retire && m_ie && !m_exl && (elig != 0) && !rfe;
    vec  = VB + win * (32'd1 << VS);
    case (cp0_sel)
      5'd12:   rd = (m_mask << 8) + (m_exl ? 32'd2 : 32'd0) + (m_ie ? 32'd1 : 32'd0);
      5'd13:   rd = (pend << 8) + (m_idx << 2);
      5'd14:   rd = m_epc;
      default: rd = 0;
    endcase
  endfunction

  task automatic apply(input logic [N-1:0] hw, input bit ret, input logic [31:0] pcn,
                       input bit rf, input bit men, input logic [4:0] sel,
                       input logic [31:0] wd);
    bit take;
    logic [31:0] win, vec, rd;
    hwint = hw; retire = ret; pc_next = pcn; rfe = rf;
    mtc0_en = men; cp0_sel = sel; cp0_wdata = wd;
    #1;
    model_comb(take, win, vec, rd);
    chk("exc_take", 32'(exc_take), 32'(take));
    chk("exc_vector", exc_vector, vec);
    chk($sformatf("rdata_sel%0d", sel), cp0_rdata, rd);
    chk("epc", epc, m_epc);
    chk("irq_ack", 32'(irq_ack), m_ack);
  endtask

  task automatic edge_();
    bit take;
    logic [31:0] win, vec, rd, clr;
    model_comb(take, win, vec, rd);
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      m_ack = take ? (32'd1 << win) : 32'd0;
      if (mtc0_en && cp0_sel == 5'd12) begin
        m_ie = cp0_wdata[0]; m_exl = cp0_wdata[1]; m_mask = (cp0_wdata >> 8) & NMASK;
      end
      if (mtc0_en && cp0_sel == 5'd14) m_epc = cp0_wdata;
      if (rfe) m_exl = 0;
      if (take) begin
        m_epc = pc_next; m_exl = 1; m_idx = win;
      end
      clr = take ? (32'd1 << win) : 32'd0;
      if (mtc0_en && cp0_sel == 5'd13) clr = clr | ((cp0_wdata >> 8) & NMASK);
      m_pend   = (m_pend & ~clr) | (32'(hwint) & ~m_hwprev);
      m_hwprev = 32'(hwint);
    end
    #1;
  endtask

  initial begin
    model_reset();
    // Power-on reset
    apply(4'h0, 0, 0, 0, 0, 5'd12, 0); edge_();
    apply(4'h0, 0, 0, 0, 0, 5'd13, 0); edge_();
    reset_n = 1'b1;
    apply(4'h0, 0, 0, 0, 0, 5'd14, 0);
    chk("por_epc_read", cp0_rdata, 32'h0);
    edge_();

    // Single take
    apply(4'h0, 0, 0, 0, 1, 5'd12, 32'h0301); edge_();
    apply(4'b0010, 1, 32'h24, 0, 0, 5'd12, 0);
    chk("single_take", 32'(exc_take), 32'h1);
    chk("single_vec", exc_vector, 32'h110);
    edge_();
    apply(4'h0, 0, 0, 0, 0, 5'd12, 0);
    chk("single_status", cp0_rdata, 32'h0303);
    chk("single_epc", epc, 32'h24);
    chk("single_ack", 32'(irq_ack), 32'h2);
    edge_();
    apply(4'h0, 0, 0, 0, 0, 5'd13, 0);
    chk("single_cause", cp0_rdata, 32'h4);
    chk("single_ack_gone", 32'(irq_ack), 32'h0);
    edge_();

    // Priority and mask
    apply(4'h0, 0, 0, 0, 1, 5'd12, 32'h0A01); edge_();
    apply(4'b1011, 1, 32'h30, 0, 0, 5'd13, 0);
    chk("prio_take", 32'(exc_take), 32'h1);
    chk("prio_vec", exc_vector, 32'h110);
    edge_();

    // Blocked by EXL, then rfe
    apply(4'h0, 0, 0, 0, 1, 5'd12, 32'h0F03); edge_();
    apply(4'b0001, 1, 32'h44, 0, 0, 5'd12, 0);
    chk("exl_block", 32'(exc_take), 32'h0);
    edge_();
    apply(4'b0001, 1, 32'h48, 1, 0, 5'd14, 0);
    chk("rfe_no_take", 32'(exc_take), 32'h0);
    chk("rfe_epc", epc, 32'h30);
    edge_();
    apply(4'b0001, 1, 32'h50, 0, 0, 5'd12, 0);
    chk("after_rfe_take", 32'(exc_take), 32'h1);
    chk("after_rfe_vec", exc_vector, 32'h100);
    edge_();

    // rfe with eligible irq, then take together with mtc0 Status
    apply(4'b0001, 1, 32'h60, 1, 0, 5'd12, 0);
    chk("rfe_irq_same", 32'(exc_take), 32'h0);
    edge_();
    apply(4'b0001, 1, 32'h64, 0, 1, 5'd12, 32'h0F01);
    chk("take_mtc0_take", 32'(exc_take), 32'h1);
    edge_();
    apply(4'h0, 0, 0, 0, 0, 5'd12, 0);
    chk("take_mtc0_status", cp0_rdata, 32'h0F03);
    edge_();

    // Mid-run asynchronous reset
    apply(4'h0, 0, 0, 0, 1, 5'd14, 32'h40); edge_();
    apply(4'b0001, 0, 0, 0, 0, 5'd14, 0);
    chk("pre_reset_epc", epc, 32'h40);
    edge_();
    hwint = '0; retire = 1'b0; rfe = 1'b0; mtc0_en = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_take", 32'(exc_take), 32'h0);
    chk("rst_epc", epc, 32'h0);
    cp0_sel = 5'd12; #1; chk("rst_status", cp0_rdata, 32'h0);
    cp0_sel = 5'd13; #1; chk("rst_cause", cp0_rdata, 32'h0);
    cp0_sel = 5'd14; #1; chk("rst_epcreg", cp0_rdata, 32'h0);
    edge_();
    reset_n = 1'b1;
    apply(4'h0, 0, 0, 0, 0, 5'd12, 0);
    chk("rel_status", cp0_rdata, 32'h0);
    edge_();

`ifdef CP0_EDGE_EN
    // Sticky pending while IE=0, then take clears it
    apply(4'h0, 0, 0, 0, 1, 5'd12, 32'h0400); edge_();
    apply(4'b0100, 0, 0, 0, 0, 5'd12, 0); edge_();
    apply(4'h0, 0, 0, 0, 0, 5'd13, 0);
    chk("edge_sticky", cp0_rdata, 32'h400);
    edge_();
    apply(4'h0, 0, 0, 0, 1, 5'd12, 32'h0401); edge_();
    apply(4'h0, 1, 32'h80, 0, 0, 5'd13, 0);
    chk("edge_take", 32'(exc_take), 32'h1);
    chk("edge_vec", exc_vector, 32'h120);
    edge_();
    apply(4'h0, 0, 0, 0, 0, 5'd13, 0);
    chk("edge_cleared", cp0_rdata, 32'h8);
    edge_();
    // W1C clear without a take (EXL still set)
    apply(4'b0100, 0, 0, 0, 0, 5'd13, 0); edge_();
    apply(4'h0, 0, 0, 0, 1, 5'd13, 32'h400); edge_();
    apply(4'h0, 0, 0, 0, 0, 5'd13, 0);
    chk("edge_w1c", cp0_rdata, 32'h8);
    edge_();
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [N-1:0] hw;
      bit ret, rf, men;
      logic [4:0] sel;
      logic [31:0] wd, sels;
      hw   = N'($urandom);
      ret  = ($urandom_range(0, 3) != 0);
      rf   = ($urandom_range(0, 7) == 0);
      men  = ($urandom_range(0, 5) == 0);
      sels = $urandom_range(0, 3);
      sel  = (sels == 3) ? 5'd3 : 5'(12 + sels);
      wd   = $urandom;
      if (rf && men && sel == 5'd12) rf = 0;
      apply(hw, ret, $urandom & 32'hFFFF_FFFC, rf, men, sel, wd);
      edge_();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
